// File: rtl/cpu_ctrl_fsm.sv
// Eight-phase instruction sequencer for a small accumulator CPU.
// Control strobes are a combinational decode of the phase register, the halt flag, opcode and zero.
module cpu_ctrl_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       alu_ena,
    output logic       rd,
    output logic       wr,
    output logic       load_ir,
    output logic       load_acc,
    output logic       load_pc,
    output logic       inc_pc,
    output logic       datactl_ena,
    output logic       halt
);

    typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5, S6, S7} state_e;

    localparam logic [2:0] OpHlt = 3'b000;
    localparam logic [2:0] OpSkz = 3'b001;
    localparam logic [2:0] OpAdd = 3'b010;
    localparam logic [2:0] OpAnd = 3'b011;
    localparam logic [2:0] OpXor = 3'b100;
    localparam logic [2:0] OpLda = 3'b101;
    localparam logic [2:0] OpSto = 3'b110;
    localparam logic [2:0] OpJmp = 3'b111;

    state_e state_q, state_d;
    logic   halted_q, halted_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    // Once halted the sequencer parks in S3 until reset, ignoring ena.
    always_comb begin
        state_d  = S0;
        halted_d = halted_q;
        if (halted_q) begin
            state_d = S3;
        end else if (!ena) begin
            state_d = S0;
        end else if ((state_q == S3) && (opcode == OpHlt)) begin
            state_d  = S3;
            halted_d = 1'b1;
        end else begin
            state_d = state_e'(state_q + 3'd1);
        end
    end

    // Unknown opcodes match no case item, so S3..S7 emit nothing for them.
    always_comb begin
        alu_ena     = 1'b0;
        rd          = 1'b0;
        wr          = 1'b0;
        load_ir     = 1'b0;
        load_acc    = 1'b0;
        load_pc     = 1'b0;
        inc_pc      = 1'b0;
        datactl_ena = 1'b0;
        halt        = 1'b0;
        if (!rst_n) begin
            halt = 1'b0;
        end else if (halted_q) begin
            halt = 1'b1;
        end else if (ena) begin
            unique case (state_q)
                S0: begin
                    rd      = 1'b1;
                    load_ir = 1'b1;
                end
                S1: begin
                    rd      = 1'b1;
                    load_ir = 1'b1;
                    inc_pc  = 1'b1;
                end
                S2: ;
                S3: begin
                    case (opcode)
                        OpHlt: halt = 1'b1;
                        OpSkz, OpAdd, OpAnd, OpXor, OpLda, OpSto, OpJmp: inc_pc = 1'b1;
                        default: ;
                    endcase
                end
                S4: begin
                    case (opcode)
                        OpAdd, OpAnd, OpXor, OpLda: begin
                            rd      = 1'b1;
                            alu_ena = 1'b1;
                        end
                        OpSto:   datactl_ena = 1'b1;
                        OpJmp:   load_pc = 1'b1;
                        default: ;
                    endcase
                end
                S5: begin
                    case (opcode)
                        OpAdd, OpAnd, OpXor, OpLda: begin
                            rd       = 1'b1;
                            load_acc = 1'b1;
                        end
                        OpSto: begin
                            datactl_ena = 1'b1;
                            wr          = 1'b1;
                        end
                        OpJmp: begin
                            load_pc = 1'b1;
                            inc_pc  = 1'b1;
                        end
                        OpSkz: begin
                            if (zero) inc_pc = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S6: begin
                    case (opcode)
                        OpAdd, OpAnd, OpXor, OpLda: rd = 1'b1;
                        OpSto:   datactl_ena = 1'b1;
                        default: ;
                    endcase
                end
                S7: begin
                    case (opcode)
                        OpSkz: begin
                            if (zero) inc_pc = 1'b1;
                        end
                        default: ;
                    endcase
                end
            endcase
        end
    end

    wr_needs_bus: assert property (@(posedge clk) disable iff (!rst_n) wr |-> datactl_ena);
    no_rd_wr:     assert property (@(posedge clk) disable iff (!rst_n) !(wr && rd));

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed bench for cpu_ctrl_fsm: per-phase strobe vectors checked against hand-written tables.
module tb_cpu_ctrl_fsm;

    localparam logic [8:0] ALU  = 9'h001;
    localparam logic [8:0] RD   = 9'h002;
    localparam logic [8:0] WR   = 9'h004;
    localparam logic [8:0] LIR  = 9'h008;
    localparam logic [8:0] LACC = 9'h010;
    localparam logic [8:0] LPC  = 9'h020;
    localparam logic [8:0] INC  = 9'h040;
    localparam logic [8:0] DCTL = 9'h080;
    localparam logic [8:0] HLT  = 9'h100;
    localparam logic [8:0] NONE = 9'h000;

    localparam logic [2:0] OpHlt = 3'b000;
    localparam logic [2:0] OpSkz = 3'b001;
    localparam logic [2:0] OpAdd = 3'b010;
    localparam logic [2:0] OpAnd = 3'b011;
    localparam logic [2:0] OpXor = 3'b100;
    localparam logic [2:0] OpLda = 3'b101;
    localparam logic [2:0] OpSto = 3'b110;
    localparam logic [2:0] OpJmp = 3'b111;

    // Expected strobes for phases S0..S7, S0 in the top slice.
    localparam logic [26:0] FETCH   = {RD | LIR, RD | LIR | INC, NONE};
    localparam logic [71:0] ALU_SEQ = {FETCH, INC, RD | ALU, RD | LACC, RD, NONE};
    localparam logic [71:0] SKZ1    = {FETCH, INC, NONE, INC, NONE, INC};
    localparam logic [71:0] SKZ0    = {FETCH, INC, NONE, NONE, NONE, NONE};
    localparam logic [71:0] STO_SEQ = {FETCH, INC, DCTL, DCTL | WR, DCTL, NONE};
    localparam logic [71:0] JMP_SEQ = {FETCH, INC, LPC, LPC | INC, NONE, NONE};
    localparam logic [71:0] HLT_SEQ = {FETCH, HLT, NONE, NONE, NONE, NONE};

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [2:0] opcode;
    logic       zero;
    logic       alu_ena, rd, wr, load_ir, load_acc, load_pc, inc_pc, datactl_ena, halt;
    logic [8:0] outs;

    int n_tests = 0;
    int n_fail  = 0;

    cpu_ctrl_fsm dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .opcode      (opcode),
        .zero        (zero),
        .alu_ena     (alu_ena),
        .rd          (rd),
        .wr          (wr),
        .load_ir     (load_ir),
        .load_acc    (load_acc),
        .load_pc     (load_pc),
        .inc_pc      (inc_pc),
        .datactl_ena (datactl_ena),
        .halt        (halt)
    );

    assign outs = {halt, datactl_ena, inc_pc, load_pc, load_acc, load_ir, wr, rd, alu_ena};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [2:0] exp);
        logic [2:0] st;
        st = dut.state_q;
        check_eq(tag, {6'b0, st}, {6'b0, exp});
    endtask

    // Entered just after a negedge; checks n phases starting from the current one.
    task automatic run_seq(input string tag, input logic [2:0] op, input logic [7:0] zb,
                           input logic [71:0] seq, input int n);
        for (int i = 0; i < n; i++) begin
            opcode = op;
            zero   = zb[i];
            #1;
            check_eq($sformatf("%s_s%0d", tag, i), outs, seq[71-9*i -: 9]);
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        opcode = OpAdd;
        zero   = 1'b0;
        #2;
        check_eq("reset", outs, NONE);
        #20;
        check_eq("reset_hold", outs, NONE);
        check_state("reset_state", 3'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_seq("add", OpAdd, 8'h00, ALU_SEQ, 8);
        run_seq("and", OpAnd, 8'hff, ALU_SEQ, 8);
        run_seq("xor", OpXor, 8'h00, ALU_SEQ, 8);
        run_seq("lda", OpLda, 8'hff, ALU_SEQ, 8);
        run_seq("skz1", OpSkz, 8'hff, SKZ1, 8);
        run_seq("skz0", OpSkz, 8'h00, SKZ0, 8);
        // zero high in S5 only: one inc_pc there, none in S7
        run_seq("skz_mix", OpSkz, 8'b0010_0000, {FETCH, INC, NONE, INC, NONE, NONE}, 8);
        run_seq("sto", OpSto, 8'h00, STO_SEQ, 8);
        run_seq("jmp", OpJmp, 8'h00, JMP_SEQ, 8);

        // Asynchronous reset in S4 of ADD
        run_seq("abort", OpAdd, 8'h00, ALU_SEQ, 4);
        #1;
        check_eq("abort_s4", outs, RD | ALU);
        #1 rst_n = 1'b0;
        #1;
        check_eq("abort_rst", outs, NONE);
        check_state("abort_state", 3'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ena drop in S5 of ADD
        run_seq("ena_abort", OpAdd, 8'h00, ALU_SEQ, 5);
        #1;
        check_eq("ena_s5", outs, RD | LACC);
        ena = 1'b0;
        #1;
        check_eq("ena_low_comb", outs, NONE);
        @(negedge clk);
        #1;
        check_eq("ena_low_next", outs, NONE);
        check_state("ena_low_state", 3'd0);
        ena = 1'b1;
        run_seq("restart", OpAdd, 8'h00, ALU_SEQ, 8);

        // HLT parks in S3 regardless of ena/opcode/zero
        run_seq("hlt", OpHlt, 8'h00, HLT_SEQ, 4);
        for (int i = 0; i < 20; i++) begin
            ena    = i[0];
            opcode = 3'(i + 1);
            zero   = i[1];
            #1;
            check_eq($sformatf("halted_%0d", i), outs, HLT);
            check_state($sformatf("halted_st_%0d", i), 3'd3);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check_eq("halt_rst", outs, NONE);
        check_state("halt_rst_state", 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ena   = 1'b1;
        run_seq("post_halt", OpAdd, 8'h00, ALU_SEQ, 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl_fsm.md
CPU_CTRL_FSM -- requirements
Module: cpu_ctrl_fsm

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-low reset; there are no parameters.
REQ-002 clk  input  1  sole clock; all state updates on posedge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 ena  input  1  run enable; low = CPU stopped.
REQ-005 opcode  input  3  instruction opcode from IR: HLT=000 SKZ=001 ADD=010 ANDD=011 XORR=100 LDA=101 STO=110 JMP=111.
REQ-006 zero  input  1  accumulator-is-zero flag from ALU, sampled as-is.
REQ-007 alu_ena  output  1  ALU register enable, one cycle, for ADD/ANDD/XORR/LDA.
REQ-008 rd, wr  output  1 each  memory read / write strobes.
REQ-009 load_ir, load_acc, load_pc, inc_pc  output  1 each  IR load, ACC load, PC load, PC increment.
REQ-010 datactl_ena  output  1  data bus driver enable (ACC onto bus).
REQ-011 halt  output  1  CPU halted indicator, sticky.

Function
REQ-012 Control SHALL be an 8-state cycle S0..S7 in a 3-bit state register, advancing one state per clk with S7 -> S0, so one instruction takes exactly 8 cycles.
REQ-013 All outputs SHALL be a combinational decode of the registered state, the halted flag, opcode and zero; every output not listed for a state/opcode is 0.
REQ-014 S0: rd=1, load_ir=1 (fetch high byte).
REQ-015 S1: rd=1, load_ir=1, inc_pc=1 (fetch low byte).
REQ-016 S2: all outputs 0.
REQ-017 S3: opcode=HLT -> halt=1, set halted flag at the edge; any other opcode -> inc_pc=1.
REQ-018 S4: ADD/ANDD/XORR/LDA -> rd=1, alu_ena=1; STO -> datactl_ena=1; JMP -> load_pc=1; HLT/SKZ -> all 0.
REQ-019 S5: ADD/ANDD/XORR/LDA -> rd=1, load_acc=1; STO -> datactl_ena=1, wr=1; JMP -> load_pc=1, inc_pc=1; SKZ with zero=1 -> inc_pc=1.
REQ-020 S6: ADD/ANDD/XORR/LDA -> rd=1; STO -> datactl_ena=1; others 0.
REQ-021 S7: SKZ with zero=1 -> inc_pc=1; others 0; next state S0.
REQ-022 ALU latency: alu_ena in S4 registers the result at the S4->S5 edge; load_acc in S5 captures it at the S5->S6 edge.
REQ-023 wr SHALL be asserted only while datactl_ena is also asserted; wr and rd SHALL never be 1 in the same cycle.
REQ-024 ena=0 sampled at any posedge SHALL force state to S0; while ena=0 all outputs except halt SHALL be 0 (mid-instruction abort, restart from S0 fetch when ena returns).
REQ-025 Halted flag set: state frozen at S3, halt=1, all other outputs 0, regardless of ena, opcode or zero; cleared only by rst_n.
REQ-026 SKZ zero is evaluated independently in S5 and S7 (two inc_pc pulses skip one 2-byte instruction); zero changing between S5 and S7 is honoured per cycle.
REQ-027 Opcodes with X/Z bits SHALL produce all control outputs 0 in S3..S7 (no halt, no inc_pc).

Reset
REQ-028 rst_n low SHALL immediately (asynchronously) set state=S0 and halted=0, forcing all outputs to 0 regardless of ena.
REQ-029 Reset asserted mid-instruction SHALL abort it; first rising clk after rst_n release with ena=1 enters S1, S0 decode visible during release cycle.
REQ-030 Outputs SHALL be 0 while rst_n is low (S0 decode gated by reset).

Verification
REQ-031 ADD, ena=1, zero=0 -> rd+load_ir in S0,S1; inc_pc in S1,S3; alu_ena S4 only; load_acc S5 only; back to S0 after 8 clks.
REQ-032 SKZ zero=1 -> inc_pc in S1,S3,S5,S7 (4 pulses); SKZ zero=0 -> inc_pc in S1,S3 only.
REQ-033 STO -> datactl_ena in S4,S5,S6; wr only in S5; rd=0 in S4..S7.
REQ-034 JMP -> load_pc in S4,S5; inc_pc in S1,S3,S5.
REQ-035 HLT -> halt=1 from S3, state held at S3 for 20 clks while ena toggles; rst_n pulse -> halt=0, state S0.
REQ-036 rst_n low during S4 of ADD -> alu_ena drops to 0 immediately without clk edge; ena=0 during S5 -> next cycle S0, outputs 0.
